rv32_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core datapath (PC, IR, regfile, imm generator, ALU, bus ports).

---
 rtl/rv32_ctrl_pkg.sv | 14 +
 rtl/rv32_multicycle_ctrl_if.sv | 6 +
 rtl/rv32_ctrl_decode.sv | 37 +++
 rtl/rv32_multicycle_ctrl.sv | 77 +++++++
 tb/tb_rv32_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: opcodes, state/class enums and mux encodings shared by the multicycle controller
package rv32_ctrl_pkg;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR} class_e;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2;
  localparam logic [1:0] PC_SEQ = 2'd0, PC_REL = 2'd1, PC_ALU = 2'd2;
  // bit 3 is funct7[5] for SUB/SRA; low bits are funct3
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100, ALU_SRL = 4'b0101, ALU_OR = 4'b0110, ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_SUB = 4'b1000, ALU_SRA = 4'b1101;
endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// rv32_multicycle_ctrl_if: instruction and data bus handshakes between controller and memory side
interface rv32_multicycle_ctrl_if;
  logic ibus_req, ibus_ready, dbus_read, dbus_write, dbus_ready;
  modport master (output ibus_req, dbus_read, dbus_write, input ibus_ready, dbus_ready);
  modport slave (input ibus_req, dbus_read, dbus_write, output ibus_ready, dbus_ready);
endinterface

// File: rtl/rv32_ctrl_decode.sv
// rv32_ctrl_decode: opcode/funct decode into immediate type, ALU function and instruction class
module rv32_ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  imm_sel,
  output logic [3:0]  alu_op,
  output logic        alu_src_b,
  output class_e      cls,
  output logic        legal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic alt, unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  // immediates reuse funct7[5] only for SRAI, since ADDI has no SUB form
  assign alt = instr[30] & (op == OP_R ? (f3 == 3'b000 || f3 == 3'b101) : f3 == 3'b101);
  always_comb begin
    legal = 1'b1;
    cls = CL_ALU;
    imm_sel = IMM_I;
    alu_src_b = 1'b1;
    alu_op = ALU_ADD;
    case (op)
      OP_R: begin alu_src_b = 1'b0; alu_op = {alt, f3}; end
      OP_I: alu_op = {alt, f3};
      OP_LOAD: cls = CL_LOAD;
      OP_STORE: begin cls = CL_STORE; imm_sel = IMM_S; end
      OP_BRANCH: begin cls = CL_BRANCH; imm_sel = IMM_B; alu_src_b = 1'b0; alu_op = ALU_SUB; end
      OP_JAL: begin cls = CL_JAL; imm_sel = IMM_J; end
      OP_JALR: cls = CL_JALR;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout and retire counter
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  rv32_multicycle_ctrl_if.master bus,
  input  logic [31:0]         instr,
  input  logic                alu_zero,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic [2:0]          imm_sel,
  output logic                alu_src_b,
  output logic [3:0]          alu_op,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    retired_cnt
);
  state_e state;
  class_e cls;
  logic legal, ready, tmo, link;
  logic [31:0] wait_cnt;
  rv32_ctrl_decode u_dec (.instr, .imm_sel, .alu_op, .alu_src_b, .cls, .legal);
  assign ready = state == FETCH ? bus.ibus_ready : bus.dbus_ready;
  assign tmo = TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1);
  assign link = cls == CL_JAL || cls == CL_JALR;
  always_comb begin
    bus.ibus_req = !rst && state == FETCH;
    bus.dbus_read = !rst && state == MEM && cls == CL_LOAD;
    bus.dbus_write = !rst && state == MEM && cls == CL_STORE;
    ir_we = bus.ibus_req && bus.ibus_ready;
    reg_we = !rst && state == WB && instr[11:7] != 5'd0;
    pc_we = ir_we || (!rst && state == EXEC && cls == CL_BRANCH && alu_zero) || (!rst && state == WB && link);
    pc_src = state == FETCH ? PC_SEQ : cls == CL_JALR ? PC_ALU : PC_REL;
    wb_sel = cls == CL_LOAD ? WB_MEM : link ? WB_LINK : WB_ALU;
  end
  // wait_cnt defaults to zero so every state change re-arms the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      retired_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        FETCH, MEM: if (ready) begin
          state <= state == FETCH ? DECODE : cls == CL_LOAD ? WB : FETCH;
          if (state == MEM && cls != CL_LOAD) retired_cnt <= retired_cnt + CNT_W'(1);
        end else if (tmo) begin
          state <= TRAP;
          bus_err <= 1'b1;
        end else wait_cnt <= wait_cnt + 32'd1;
        DECODE: begin
          state <= legal ? EXEC : TRAP;
          illegal <= !legal;
        end
        EXEC: begin
          state <= cls == CL_LOAD || cls == CL_STORE ? MEM : cls == CL_BRANCH ? FETCH : WB;
          if (cls == CL_BRANCH) retired_cnt <= retired_cnt + CNT_W'(1);
        end
        WB: begin
          state <= FETCH;
          retired_cnt <= retired_cnt + CNT_W'(1);
        end
        default: state <= TRAP;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl: per-instruction cycle traces built from the phase rules, checked every cycle
module tb_rv32_multicycle_ctrl;
  import rv32_ctrl_pkg::*;
  logic clk = 0, rst = 1, alu_zero = 0;
  logic [31:0] instr = '0;
  logic ir_we, pc_we, alu_src_b, reg_we, illegal, bus_err;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] imm_sel;
  logic [3:0] alu_op;
  logic [31:0] retired_cnt;
  rv32_multicycle_ctrl_if bus();
  rv32_multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .instr(instr), .alu_zero(alu_zero),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
    .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    bit ps, rs, ir, dr, z;
    logic [31:0] ins;
    bit req, rd, wr, irwe, pcwe, regwe, ill, berr;
    bit immchk, wbchk, aluchk, srcb;
    logic [1:0] pcs, wbs;
    logic [2:0] imm;
    logic [3:0] alu;
    int ret;
  } cyc_t;
  cyc_t q[$];
  bit mark, m_ill, m_berr;
  int m_ret;
  int total, bad, cyc_i, first_ir, last_reg, n_irwe, n_regwe, n_dread, n_pcwe, n_req, first_ret;
  event cmp_done;
  task automatic chk1(input string nm, input logic act, input bit exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time); end
  endtask
  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time); end
  endtask
  task automatic push(input cyc_t c);
    c.ps = mark;
    mark = 0;
    c.ill = m_ill;
    c.berr = m_berr;
    c.ret = m_ret;
    q.push_back(c);
  endtask
  function automatic logic [3:0] exp_alu(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    if (op != 7'h33 && op != 7'h13) return op == 7'h63 ? ALU_SUB : ALU_ADD;
    case (i[14:12])
      3'd0: return (op == 7'h33 && i[30]) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return i[30] ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  // one instruction: fw fetch waits, mw memory waits, z = alu_zero in EXEC
  task automatic gen_instr(input logic [31:0] ins, input int fw, input int mw, input bit z);
    cyc_t b, c;
    logic [6:0] op;
    bit r, ld, st, br, jal, jalr, legal;
    op = ins[6:0];
    r = op == 7'h33; ld = op == 7'h03; st = op == 7'h23;
    br = op == 7'h63; jal = op == 7'h6F; jalr = op == 7'h67;
    legal = r | ld | st | br | jal | jalr | (op == 7'h13);
    b = '0;
    b.ins = ins;
    c = b; c.req = 1;
    repeat (fw) push(c);
    c.ir = 1; c.irwe = 1; c.pcwe = 1;
    push(c);
    b.imm = st ? 3'd1 : br ? 3'd2 : jal ? 3'd3 : 3'd0;
    b.immchk = legal && !r;
    push(b);
    if (!legal) begin m_ill = 1; return; end
    c = b; c.aluchk = 1; c.alu = exp_alu(ins); c.srcb = !(r || br); c.z = z;
    if (br) begin c.pcwe = z; c.pcs = 2'd1; push(c); m_ret++; return; end
    push(c);
    if (ld || st) begin
      c = b; c.rd = ld; c.wr = st;
      repeat (mw) push(c);
      c.dr = 1;
      push(c);
      if (st) begin m_ret++; return; end
    end
    c = b;
    c.regwe = ins[11:7] != 5'd0; c.wbchk = 1;
    c.wbs = ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0;
    c.pcwe = jal || jalr; c.pcs = jalr ? 2'd2 : 2'd1;
    push(c);
    m_ret++;
  endtask
  task automatic gen_trap(input logic [31:0] ins, input int n);
    cyc_t c;
    c = '0; c.ins = ins; c.ir = 1; c.dr = 1;
    repeat (n) push(c);
  endtask
  task automatic gen_reset(input int n);
    cyc_t c;
    c = '0; c.rs = 1; c.ir = 1; c.dr = 1;
    repeat (n) begin push(c); m_ill = 0; m_berr = 0; m_ret = 0; end
  endtask
  task automatic gen_timeout(input logic [31:0] ins);
    cyc_t c;
    c = '0; c.ins = ins; c.req = 1;
    repeat (16) push(c);
    m_berr = 1;
    gen_trap(ins, 3);
  endtask
  task automatic run();
    int g;
    g = 0;
    while (q.size() != 0 && g < 400) begin @(cmp_done); g++; end
    chkv("drain", 32'(q.size()), 0);
  endtask
  initial begin : cmp
    cyc_t c;
    bus.ibus_ready = 0;
    bus.dbus_ready = 0;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        c = q.pop_front();
        rst = c.rs; bus.ibus_ready = c.ir; bus.dbus_ready = c.dr; alu_zero = c.z; instr = c.ins;
        #1;
        if (c.ps) begin
          cyc_i = 0; first_ir = -1; last_reg = -1;
          n_irwe = 0; n_regwe = 0; n_dread = 0; n_pcwe = 0; n_req = 0;
          first_ret = retired_cnt;
        end
        cyc_i++;
        if (ir_we === 1'b1 && first_ir < 0) first_ir = cyc_i;
        if (reg_we === 1'b1) last_reg = cyc_i;
        n_irwe += int'(ir_we); n_regwe += int'(reg_we); n_dread += int'(bus.dbus_read);
        n_pcwe += int'(pc_we); n_req += int'(bus.ibus_req);
        chk1("ibus_req", bus.ibus_req, c.req);
        chk1("dbus_read", bus.dbus_read, c.rd);
        chk1("dbus_write", bus.dbus_write, c.wr);
        chk1("ir_we", ir_we, c.irwe);
        chk1("pc_we", pc_we, c.pcwe);
        chk1("reg_we", reg_we, c.regwe);
        chk1("illegal", illegal, c.ill);
        chk1("bus_err", bus_err, c.berr);
        chkv("retired_cnt", retired_cnt, 32'(c.ret));
        if (c.pcwe) chkv("pc_src", 32'(pc_src), 32'(c.pcs));
        if (c.wbchk) chkv("wb_sel", 32'(wb_sel), 32'(c.wbs));
        if (c.immchk) chkv("imm_sel", 32'(imm_sel), 32'(c.imm));
        if (c.aluchk) begin
          chkv("alu_op", 32'(alu_op), 32'(c.alu));
          chk1("alu_src_b", alu_src_b, c.srcb);
        end
        -> cmp_done;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int save;
    mark = 1; gen_reset(2); run();
    mark = 1; gen_instr(32'h00500093, 0, 0, 0); run();
    chkv("addi_span", 32'(last_reg - first_ir + 1), 4);
    chkv("addi_regwe_n", n_regwe, 1);
    chkv("addi_irwe_n", n_irwe, 1);
    mark = 1; gen_instr(32'h00208033, 0, 0, 0); run();
    chkv("ret_after_addi", first_ret, 1);
    chkv("x0_regwe_n", n_regwe, 0);
    mark = 1; gen_instr(32'h0080A283, 0, 3, 0); run();
    chkv("lw_dread_n", n_dread, 4);
    chkv("lw_span", 32'(last_reg - first_ir + 1), 8);
    mark = 1; gen_instr(32'h0050A623, 0, 0, 0); run();
    chkv("ret_before_sw", first_ret, 3);
    chkv("sw_cycles", cyc_i, 4);
    mark = 1; gen_instr(32'h00208463, 0, 0, 1); run();
    chkv("beq_taken_pcwe_n", n_pcwe, 2);
    chkv("beq_taken_cycles", cyc_i, 3);
    mark = 1; gen_instr(32'h00208463, 0, 0, 0); run();
    chkv("beq_not_pcwe_n", n_pcwe, 1);
    chkv("ret_before_beq2", first_ret, 5);
    mark = 1; gen_instr(32'h010000EF, 0, 0, 0); run();
    chkv("ret_before_jal", first_ret, 6);
    chkv("jal_pcwe_n", n_pcwe, 2);
    mark = 1; gen_instr(32'h00008067, 0, 0, 0); run();
    chkv("ret_before_jalr", first_ret, 7);
    chkv("jalr_regwe_n", n_regwe, 0);
    mark = 1; gen_instr(32'h00500093, 15, 0, 0); run();
    chkv("late_fetch_req_n", n_req, 16);
    chk1("late_fetch_no_err", bus_err, 1'b0);
    save = m_ret;
    mark = 1; gen_instr(32'h0050A623, 0, 5, 0);
    repeat (3) void'(q.pop_back());
    m_ret = save;
    gen_reset(1); run();
    chkv("ret_before_rst", first_ret, 9);
    mark = 1; gen_instr(32'h00500093, 0, 0, 0); run();
    chkv("ret_after_rst", first_ret, 0);
    mark = 1; gen_instr(32'h0000007F, 0, 0, 0); gen_trap(32'h0000007F, 4); run();
    chkv("illegal_req_n", n_req, 1);
    chk1("illegal_sticky", illegal, 1'b1);
    chkv("illegal_ret_hold", retired_cnt, 1);
    mark = 1; gen_reset(1); gen_timeout(32'h00500093); run();
    chkv("timeout_req_n", n_req, 16);
    chk1("timeout_err", bus_err, 1'b1);
    mark = 1; gen_reset(1); gen_instr(32'h00500093, 0, 0, 0); run();
    chkv("final_regwe_n", n_regwe, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
